// File: rtl/dice_game_multi.sv
// dice_game_multi: craps-style game core; NUM_DICE ripple-spun dice, scored on roll release
// Ports: clock, reset (async, active-high), roll (level), disp (7-seg gfedcba per die, die k at [7k+6:7k]),
//   point (stored point, 0 when none), win/lose (latched flags), roll_cnt (point-phase rolls, ROLL_LIMIT_EN only)
// Option: define ROLL_LIMIT_EN to lose once MAX_PTROLL point-phase rolls pass without a win
module dice_game_multi #(
  parameter int NUM_DICE = 2,
  parameter int NUM_FACES = 6,
  parameter int WIN_A = 7,
  parameter int WIN_B = 11,
  parameter int LOSE_A = 2,
  parameter int LOSE_B = 3,
  parameter int LOSE_C = 12,
`ifdef ROLL_LIMIT_EN
  parameter int MAX_PTROLL = 8,
`endif
  localparam int DW = $clog2(NUM_FACES + 1),
  localparam int SUM_W = $clog2(NUM_DICE * NUM_FACES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  roll,
  output logic [7*NUM_DICE-1:0] disp,
  output logic [SUM_W-1:0]      point,
  output logic                  win,
  output logic                  lose
`ifdef ROLL_LIMIT_EN
  ,
  output logic [3:0]            roll_cnt
`endif
);
  typedef enum logic [1:0] {S_FIRST, S_POINT, S_WIN, S_LOSE} state_e;
  state_e state_q, state_d;
  logic [DW-1:0] die_q [NUM_DICE];
  logic [DW-1:0] die_d [NUM_DICE];
  logic [SUM_W-1:0] point_q, point_d, sum;
  logic roll_q, rel, hit_w, hit_l;
`ifdef ROLL_LIMIT_EN
  logic [3:0] cnt_q, cnt_d;
  assign roll_cnt = cnt_q;
`endif
  function automatic logic [6:0] seg(input logic [DW-1:0] v);
    case (v)
      DW'(1): seg = 7'h06;
      DW'(2): seg = 7'h5B;
      DW'(3): seg = 7'h4F;
      DW'(4): seg = 7'h66;
      DW'(5): seg = 7'h6D;
      DW'(6): seg = 7'h7D;
      DW'(7): seg = 7'h07;
      DW'(8): seg = 7'h7F;
      DW'(9): seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction
  // Odometer: a die only steps when every lower die wraps this cycle.
  always_comb begin : ripple
    logic c;
    c = roll;
    sum = '0;
    disp = '0;
    for (int k = 0; k < NUM_DICE; k++) begin
      die_d[k] = !c ? die_q[k] : die_q[k] == DW'(NUM_FACES) ? DW'(1) : die_q[k] + DW'(1);
      c = c && die_q[k] == DW'(NUM_FACES);
      sum = sum + SUM_W'(die_q[k]);
      disp[7*k +: 7] = seg(die_q[k]);
    end
  end
  assign rel = roll_q & ~roll;
  assign hit_w = sum == SUM_W'(WIN_A) || sum == SUM_W'(WIN_B);
  assign hit_l = sum == SUM_W'(LOSE_A) || sum == SUM_W'(LOSE_B) || sum == SUM_W'(LOSE_C);
  always_comb begin
    state_d = state_q;
    point_d = point_q;
`ifdef ROLL_LIMIT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      S_FIRST: if (rel) begin
        state_d = hit_w ? S_WIN : hit_l ? S_LOSE : S_POINT;
        point_d = hit_w || hit_l ? point_q : sum;
`ifdef ROLL_LIMIT_EN
        cnt_d = '0;
`endif
      end
      S_POINT: if (rel) begin
`ifdef ROLL_LIMIT_EN
        cnt_d = cnt_q + 4'd1;
        state_d = sum == point_q ? S_WIN : sum == SUM_W'(WIN_A) || cnt_d == 4'(MAX_PTROLL) ? S_LOSE : S_POINT;
`else
        state_d = sum == point_q ? S_WIN : sum == SUM_W'(WIN_A) ? S_LOSE : S_POINT;
`endif
      end
      default: if (roll) begin
        state_d = S_FIRST;
        point_d = '0;
`ifdef ROLL_LIMIT_EN
        cnt_d = '0;
`endif
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FIRST;
      point_q <= '0;
      roll_q <= 1'b0;
      die_q <= '{default: DW'(1)};
`ifdef ROLL_LIMIT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      point_q <= point_d;
      roll_q <= roll;
      die_q <= die_d;
`ifdef ROLL_LIMIT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign point = point_q;
  assign win = state_q == S_WIN;
  assign lose = state_q == S_LOSE;
endmodule

// File: tb/tb_dice_game_multi.sv
// tb_dice_game_multi: directed self-checking bench for dice_game_multi (2 dice, 6 faces)
module tb_dice_game_multi;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic roll = 1'b0;
  logic [13:0] disp;
  logic [3:0] point;
  logic win, lose;
  int n_chk = 0;
  int n_pass = 0;
`ifdef ROLL_LIMIT_EN
  logic [3:0] roll_cnt;
  dice_game_multi #(.MAX_PTROLL(2)) dut (
    .clock(clock), .reset(reset), .roll(roll), .disp(disp), .point(point),
    .win(win), .lose(lose), .roll_cnt(roll_cnt));
`else
  dice_game_multi dut (
    .clock(clock), .reset(reset), .roll(roll), .disp(disp), .point(point),
    .win(win), .lose(lose));
`endif
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_reset();
    @(negedge clock);
    roll = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic roll_for(input int n);
    @(negedge clock);
    roll = 1'b1;
    repeat (n) @(negedge clock);
    roll = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    do_reset();
    check("rst_disp", 32'(disp), 32'h306);
    check("rst_point", 32'(point), 0);
    check("rst_win", 32'(win), 0);
    check("rst_lose", 32'(lose), 0);
    roll_for(5);
    check("nat_disp", 32'(disp), 32'h37D);
    check("nat_win", 32'(win), 1);
    check("nat_lose", 32'(lose), 0);
    check("nat_point", 32'(point), 0);
    @(negedge clock);
    roll = 1'b1;
    @(negedge clock);
    check("new_win", 32'(win), 0);
    check("new_spin", 32'(disp), 32'h2D86);
    roll = 1'b0;
    @(negedge clock);
    check("new_lose", 32'(lose), 1);
    do_reset();
    roll_for(1);
    check("craps_disp", 32'(disp), 32'h35B);
    check("craps_lose", 32'(lose), 1);
    check("craps_win", 32'(win), 0);
    check("craps_point", 32'(point), 0);
    do_reset();
    roll_for(2);
    check("pt_disp", 32'(disp), 32'h34F);
    check("pt_point", 32'(point), 4);
    check("pt_flags", 32'({win, lose}), 0);
    roll_for(8);
    check("seven_disp", 32'(disp), 32'h2DED);
    check("seven_lose", 32'(lose), 1);
    check("seven_win", 32'(win), 0);
    do_reset();
    roll_for(2);
    roll_for(36);
    check("make_disp", 32'(disp), 32'h34F);
    check("make_win", 32'(win), 1);
    check("make_lose", 32'(lose), 0);
    do_reset();
    roll_for(2);
    @(negedge clock);
    roll = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_disp", 32'(disp), 32'h306);
    check("arst_point", 32'(point), 0);
    check("arst_flags", 32'({win, lose}), 0);
    @(negedge clock);
    roll = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("arst_noscore", 32'({win, lose}), 0);
    check("arst_nopoint", 32'(point), 0);
`ifdef ROLL_LIMIT_EN
    do_reset();
    roll_for(2);
    check("lim_cnt0", 32'(roll_cnt), 0);
    roll_for(1);
    check("lim_cnt1", 32'(roll_cnt), 1);
    check("lim_nolose", 32'(lose), 0);
    roll_for(1);
    check("lim_cnt2", 32'(roll_cnt), 2);
    check("lim_lose", 32'(lose), 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
